// File: rtl/muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit that owns the architectural HI/LO registers.
// Signed MULT/DIV support is built only when MULDIV_SIGNED_EN is defined; otherwise op[1] is ignored.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             en_hi,
  input  logic             en_lo,
  input  logic [WIDTH-1:0] data_w,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state, state_next;

  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   acc_hi;   // product upper half, or partial remainder
  logic [WIDTH-1:0] acc_lo;   // multiplier bits, or dividend/quotient bits
  logic [WIDTH-1:0] opnd;     // multiplicand, or divisor
  logic             div_zero;

  logic             idle_like;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH+1:0] div_shift;
  logic [WIDTH+1:0] div_diff;
  logic [WIDTH:0]   hi_step;
  logic [WIDTH-1:0] lo_step;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign idle_like = (state == IDLE) || (state == DONE);
  assign accept    = start && idle_like;
  assign last      = (cnt == '0);
  assign busy      = (state == MUL) || (state == DIV);
  assign done      = (state == DONE);

`ifdef MULDIV_SIGNED_EN
  logic neg_a, neg_b;
  logic sign_a, sign_b;

  assign neg_a = op[1] & data_a[WIDTH-1];
  assign neg_b = op[1] & data_b[WIDTH-1];
  assign mag_a = neg_a ? -data_a : data_a;
  assign mag_b = neg_b ? -data_b : data_b;
`else
  logic op_sign_unused;

  assign op_sign_unused = op[1];
  assign mag_a          = data_a;
  assign mag_b          = data_b;
`endif

  // One iteration of the shared datapath; also feeds the result write on the final cycle.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    mul_sum   = {1'b0, acc_hi[WIDTH-1:0]} + {1'b0, (acc_lo[0] ? opnd : '0)};
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {2'b00, opnd};
    hi_step   = {1'b0, mul_sum[WIDTH:1]};
    lo_step   = {mul_sum[0], acc_lo[WIDTH-1:1]};
    if (state == DIV) begin
      hi_step = div_diff[WIDTH+1] ? div_shift[WIDTH:0] : div_diff[WIDTH:0];
      lo_step = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH+1]};
    end
  end

  always_comb begin
    res_hi = hi_step[WIDTH-1:0];
    res_lo = lo_step;
`ifdef MULDIV_SIGNED_EN
    if (state == MUL) begin
      if (sign_a ^ sign_b) {res_hi, res_lo} = -{hi_step[WIDTH-1:0], lo_step};
    end else begin
      if (sign_a ^ sign_b) res_lo = -lo_step;
      if (sign_a)          res_hi = -hi_step[WIDTH-1:0];
    end
`endif
    // A zero divisor leaves the dividend in the remainder; only the quotient needs forcing.
    if ((state == DIV) && div_zero) res_lo = '1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start)              state_next = op[0] ? DIV : MUL;
        else if (state == DONE) state_next = IDLE;
      end
      MUL, DIV: if (last) state_next = DONE;
      default:  state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: hi/lo are architectural and must read zero after reset, so they are reset with the rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
`ifdef MULDIV_SIGNED_EN
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
`endif
    end else if (accept) begin
      cnt      <= CW'(WIDTH - 1);
      acc_hi   <= '0;
      acc_lo   <= op[0] ? mag_a : mag_b;
      opnd     <= op[0] ? mag_b : mag_a;
      div_zero <= (data_b == '0);
`ifdef MULDIV_SIGNED_EN
      sign_a   <= neg_a;
      sign_b   <= neg_b;
`endif
    end else if (busy) begin
      acc_hi <= hi_step;
      acc_lo <= lo_step;
      cnt    <= cnt - CW'(1);
      if (last) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end else begin
      if (en_hi) hi <= data_w;
      if (en_lo) lo <= data_w;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; expectations follow MULDIV_SIGNED_EN when defined.
module tb_muldiv_unit;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_MULT  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] data_a = '0;
  logic [31:0] data_b = '0;
  logic        en_hi = 1'b0;
  logic        en_lo = 1'b0;
  logic [31:0] data_w = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .data_a(data_a), .data_b(data_b),
    .en_hi(en_hi), .en_lo(en_lo), .data_w(data_w),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Called between edges; returns the edge count from start to done and the busy cycles seen.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_n);
    start = 1'b1; op = o; data_a = a; data_b = b;
    @(posedge clk); #1;
    start = 1'b0; data_a = ~a; data_b = ~b;
    lat = 0; busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
  endtask

  task automatic test_multu;
    int lat, busy_n;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, busy_n);
    checks++; if (lat !== 32) begin errors++; $display("FAIL multu_latency: got %0d expected 32", lat); end
    checks++; if (busy_n !== 32) begin errors++; $display("FAIL multu_busy_cycles: got %0d expected 32", busy_n); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
    checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_divu_ignore_start;
    int lat;
    start = 1'b1; op = OP_DIVU; data_a = 32'd100; data_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      if (lat == 5) begin
        start = 1'b1; op = OP_MULTU; data_a = 32'd3; data_b = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    checks++; if (lat !== 32) begin errors++; $display("FAIL divu_latency: got %0d expected 32", lat); end
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h expected 0000000e", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h expected 00000002", hi); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL divu_no_queue: got busy %b expected 0", busy); end
  endtask

  task automatic test_div_zero;
    int lat, busy_n;
    run_op(OP_DIVU, 32'h1234_5678, 32'h0, lat, busy_n);
    checks++; if (lat !== 32) begin errors++; $display("FAIL div0_latency: got %0d expected 32", lat); end
    checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL div0_hi: got %h expected 12345678", hi); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo: got %h expected ffffffff", lo); end
  endtask

  task automatic test_signed_ops;
    int lat, busy_n;
    logic [31:0] exp_hi, exp_lo;
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, lat, busy_n);
`ifdef MULDIV_SIGNED_EN
    exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFF1;
`else
    exp_hi = 32'h0000_0004; exp_lo = 32'hFFFF_FFF1;
`endif
    checks++; if (hi !== exp_hi) begin errors++; $display("FAIL mult_hi: got %h expected %h", hi, exp_hi); end
    checks++; if (lo !== exp_lo) begin errors++; $display("FAIL mult_lo: got %h expected %h", lo, exp_lo); end

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, busy_n);
`ifdef MULDIV_SIGNED_EN
    exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFFD;
`else
    exp_hi = 32'h0000_0001; exp_lo = 32'h7FFF_FFFC;
`endif
    checks++; if (lat !== 32) begin errors++; $display("FAIL div_latency: got %0d expected 32", lat); end
    checks++; if (hi !== exp_hi) begin errors++; $display("FAIL div_hi: got %h expected %h", hi, exp_hi); end
    checks++; if (lo !== exp_lo) begin errors++; $display("FAIL div_lo: got %h expected %h", lo, exp_lo); end

    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, busy_n);
`ifdef MULDIV_SIGNED_EN
    exp_hi = 32'h0000_0000; exp_lo = 32'h8000_0000;
`else
    exp_hi = 32'h8000_0000; exp_lo = 32'h0000_0000;
`endif
    checks++; if (hi !== exp_hi) begin errors++; $display("FAIL div_min_hi: got %h expected %h", hi, exp_hi); end
    checks++; if (lo !== exp_lo) begin errors++; $display("FAIL div_min_lo: got %h expected %h", lo, exp_lo); end
  endtask

  task automatic test_mthi_mtlo;
    int lat;
    en_hi = 1'b1; data_w = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    en_hi = 1'b0;
    checks++; if (hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mthi_idle: got %h expected deadbeef", hi); end
    en_hi = 1'b1; en_lo = 1'b1; data_w = 32'h0123_4567;
    @(posedge clk); #1;
    en_hi = 1'b0; en_lo = 1'b0;
    checks++; if ({hi, lo} !== {2{32'h0123_4567}}) begin errors++; $display("FAIL mthi_mtlo_both: got %h_%h expected 01234567_01234567", hi, lo); end
    en_hi = 1'b1; data_w = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    en_hi = 1'b0;
    checks++; if (lo !== 32'h0123_4567) begin errors++; $display("FAIL mthi_only_lo_kept: got %h expected 01234567", lo); end

    // Writes during an operation are dropped.
    start = 1'b1; op = OP_MULTU; data_a = 32'd6; data_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; en_hi = 1'b1; data_w = 32'h1111_1111;
    repeat (5) @(posedge clk);
    #1;
    en_hi = 1'b0;
    checks++; if (hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mthi_busy_dropped: got %h expected deadbeef", hi); end
    lat = 5;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if ({hi, lo} !== {32'd0, 32'd42}) begin errors++; $display("FAIL mul_after_mthi: got %h_%h expected 00000000_0000002a", hi, lo); end

    // start wins over a simultaneous MTLO.
    start = 1'b1; op = OP_MULTU; data_a = 32'd2; data_b = 32'd3; en_lo = 1'b1; data_w = 32'hCAFE_F00D;
    @(posedge clk); #1;
    start = 1'b0; en_lo = 1'b0;
    checks++; if (lo !== 32'd42) begin errors++; $display("FAIL start_beats_mtlo: got %h expected 0000002a", lo); end
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lo !== 32'd6) begin errors++; $display("FAIL start_mtlo_result: got %h expected 00000006", lo); end
  endtask

  task automatic test_back_to_back;
    int lat, busy_n;
    run_op(OP_MULTU, 32'h0001_0000, 32'h0001_0000, lat, busy_n);
    checks++; if ({hi, lo} !== {32'd1, 32'd0}) begin errors++; $display("FAIL b2b_first: got %h_%h expected 00000001_00000000", hi, lo); end
    run_op(OP_DIVU, 32'd1000, 32'd10, lat, busy_n);
    checks++; if (lat !== 32) begin errors++; $display("FAIL b2b_latency: got %0d expected 32", lat); end
    checks++; if ({hi, lo} !== {32'd0, 32'd100}) begin errors++; $display("FAIL b2b_second: got %h_%h expected 00000000_00000064", hi, lo); end
  endtask

  task automatic test_reset_mid_op;
    int lat, busy_n;
    bit saw_done;
    start = 1'b1; op = OP_DIVU; data_a = 32'd100; data_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rst_mid_flags: got busy,done=%b%b expected 00", busy, done); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL rst_mid_hilo: got %h_%h expected 00000000_00000000", hi, lo); end
    @(posedge clk); #1;
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rst_mid_no_done: got activity %b expected 0", saw_done); end
    run_op(OP_MULTU, 32'd6, 32'd7, lat, busy_n);
    checks++; if ({hi, lo} !== {32'd0, 32'd42}) begin errors++; $display("FAIL rst_then_mul: got %h_%h expected 00000000_0000002a", hi, lo); end
  endtask

  initial begin
    test_reset;
    test_multu;
    test_divu_ignore_start;
    test_div_zero;
    test_signed_ops;
    test_mthi_mtlo;
    test_back_to_back;
    test_reset_mid_op;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle MULT/MULTU/DIV/DIVU execution unit with architectural HI/LO registers for the MIPS CPU.
- Consumes the regfile read-channel operands (data_a = rs, data_b = rt) captured by the EX stage.
- Produces HI/LO for MFHI/MFLO and a busy flag that the hazard logic uses to stall MFHI/MFLO and further mul/div issue.
- Iterative radix-2 datapath: 32 compute cycles per operation.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
- clk  in  1  main clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to begin an operation; sampled on posedge only in IDLE or DONE.
- op  in  2  operation: 00 MULTU, 01 DIVU, 10 MULT, 11 DIV.
- data_a  in  WIDTH  multiplicand / dividend (rs).
- data_b  in  WIDTH  multiplier / divisor (rt).
- en_hi  in  1  MTHI write enable.
- en_lo  in  1  MTLO write enable.
- data_w  in  WIDTH  MTHI/MTLO write data.
- busy  out  1  high while an operation is computing.
- done  out  1  one-cycle pulse in the cycle HI/LO first hold a new result.
- hi  out  WIDTH  HI register; product[63:32] or remainder.
- lo  out  WIDTH  LO register; product[31:0] or quotient.

Behaviour:
- Reset (async, any state, including mid-operation):
  - State goes to IDLE; hi = lo = 0; busy = 0; done = 0; iteration counter = 0.
  - Any in-flight operation is discarded.
- States: IDLE, MUL, DIV, DONE.
- IDLE or DONE with start=1 at posedge:
  - Latch data_a, data_b and op.
  - Enter MUL if op[0]=0, or DIV if op[0]=1; counter = WIDTH-1.
  - busy = 1 from the next cycle; done = 0.
- MUL: shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator.
- DIV: restoring division, one quotient bit per cycle. Partial remainder is WIDTH+1 bits wide.
- Counter decrements each cycle. On the posedge with counter = 0:
  - Result is written to hi/lo.
  - State goes to DONE; busy = 0; done = 1.
- Latency:
  - Start sampled at edge E0.
  - busy is high for exactly 32 cycles (E0+1 .. E0+32).
  - hi/lo are valid and done = 1 after edge E0+32.
- DONE lasts one cycle, then goes to IDLE unless start is asserted again (back-to-back operations allowed, no gap).
- hi/lo hold their value until the next result, an MTHI/MTLO write, or reset.
- start while busy=1 is ignored; no queueing.
- en_hi/en_lo:
  - In IDLE/DONE, write data_w into hi/lo on the posedge. Both may be asserted together.
  - While busy=1, ignored.
  - If start and en_hi/en_lo are asserted in the same cycle, start wins and the write is dropped.
- Divide by zero (data_b = 0), any mode:
  - Takes the full 32 cycles.
  - Result: hi = dividend, lo = 0xFFFFFFFF.
  - No exception is raised.
- Operands are latched at start, so later changes on data_a/data_b during busy have no effect.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined:
  - For op[1]=1, operands are converted to magnitudes at start.
  - The unsigned core computes on the magnitudes.
  - Sign fix-up is applied on the result write:
    - Product is negated if operand signs differ.
    - Quotient is negated if signs differ.
    - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
  - Latency is unchanged at 32 cycles.
  - Divide-by-zero rule takes precedence.
- Undefined: op[1] is ignored; MULT/DIV behave as MULTU/DIVU. No sign logic is synthesised.

Test Plan:
- Reset, then MULTU with a=0xFFFFFFFF, b=0xFFFFFFFF -> busy for 32 cycles; done pulse at E0+32; hi=0xFFFFFFFE, lo=0x00000001.
- DIVU with a=100, b=7 -> lo=14, hi=2 at E0+32. Second start pulsed at cycle E0+5 -> ignored, result unchanged.
- DIVU with a=0x12345678, b=0 -> hi=0x12345678, lo=0xFFFFFFFF after 32 cycles.
- With MULDIV_SIGNED_EN:
  - MULT a=-3 (0xFFFFFFFD), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Without the macro, the same DIV gives the unsigned result lo=0x7FFFFFFC, hi=1.
- en_hi=1, data_w=0xDEADBEEF in IDLE -> hi=0xDEADBEEF next cycle. Same write while busy -> hi unchanged until the result write. start+en_lo together -> en_lo dropped.
- rst asserted asynchronously at cycle E0+10 of a DIVU -> immediately busy=0, done=0, hi=lo=0. No done pulse follows. A new MULTU 6*7 after reset release gives lo=42, hi=0.
